tx_frame_scheduler: RTL
=======================

Name: tx_frame_scheduler

Overview:
Sequences and shares the single MAC TX client port between two frame sources: the periodic delay-probe frame generator (src0) and a control-frame source such as ARP/echo replies (src1). It issues periodic probe triggers, arbitrates ownership of the MAC port, and enforces an inter-frame gap. It also applies MAC TX configuration only between frames and counts frames sent per source. It sits directly between the frame generators and the MAC client interface in the tx_clk domain.

Parameters:
IFG_CYCLES, 12, idle tx_clk cycles enforced after each frame end before the next grant
GRANT_TIMEOUT, 64, cycles a granted source may take to assert dvld before its grant is revoked
PERIOD_W, 24, width of the probe period counter

Ports:
tx_clk  input  1  TX clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
sched_en  input  1  enables probe triggers and new grants
probe_period  input  PERIOD_W  probe trigger interval in tx_clk cycles; 0 disables triggers
cfg_jumbo_en  input  1  requested jumbo setting
cfg_no_gen_crc  input  1  requested no-CRC-generation setting
probe_trig  output  1  one-cycle pulse requesting a probe frame from src0
src0_req, src1_req  input  1 each  level request, held until the source's frame ends
src0_gnt, src1_gnt  output  1 each  grant, registered, at most one high
src0_data, src1_data  input  8 each  source byte
src0_dvld, src1_dvld  input  1 each  source data valid
src0_ack, src1_ack  output  1 each  mac_tx_ack gated by the corresponding grant
conf_tx_en  output  1  MAC TX enable
conf_tx_jumbo_en  output  1  MAC jumbo enable
conf_tx_no_gen_crc  output  1  MAC CRC-generation disable
mac_tx_data  output  8  byte to MAC
mac_tx_dvld  output  1  data valid to MAC
mac_tx_ack  input  1  MAC accepted first byte
probe_frames, ctrl_frames  output  16 each  completed frames per source, wrapping

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, period counter 0, RR pointer set so src0 wins the first tie. Reset mid-frame drops the frame immediately (mac_tx_dvld=0 at once via the gnt gating).
- Trigger: when sched_en=1 and probe_period!=0, the counter increments each cycle. When count >= probe_period-1, probe_trig=1 for one cycle and the count returns to 0. When sched_en=0 or probe_period=0, the count is held at 0 and no trigger fires. Lowering the period below the current count fires on the next cycle.
- Config: conf_tx_en <= sched_en, and conf_tx_jumbo_en/conf_tx_no_gen_crc <= cfg inputs, updated only in IDLE. Changes during a frame or IFG are deferred.
- Mux: zero-latency combinational selection from the registered grant. mac_tx_data/mac_tx_dvld = granted source's data/dvld; both 0 when no grant. srcN_ack = mac_tx_ack & srcN_gnt.
- FSM:
  IDLE: if sched_en and any req, grant the winner next cycle (-> GRANT). Both requesting: round-robin, with the pointer moving to the other source after each grant. Single requester always wins.
  GRANT: wait for the granted dvld=1 -> WAIT_ACK. The timeout counter counts from 0; reaching GRANT_TIMEOUT-1 without dvld drops the grant -> IFG, with no frame counted.
  WAIT_ACK: hold until mac_tx_ack=1 -> XFER. dvld dropping before ack is treated as abort -> IFG, with no count.
  XFER: the source streams one byte per cycle. Granted dvld=0 marks the frame end: increment that source's counter, drop the grant -> IFG.
  IFG: all grants 0 for exactly IFG_CYCLES cycles, then IDLE. Config updates in that IDLE cycle; arbitration in the same cycle.
- Requests are ignored while the other source holds the grant. A req dropped while granted does not end the frame; only dvld does.
- sched_en falling mid-frame: the current frame completes normally, and no new grants are issued afterwards.
- Grant-to-grant minimum spacing = frame + IFG_CYCLES + 1 cycles.

Test Plan:
- Reset release, sched_en=1, probe_period=100 -> probe_trig pulses at cycles 99, 199, 299 after enable; conf_tx_en=1 at the first IDLE cycle.
- src0 only: req, dvld after 3 cycles, ack 2 cycles later, 60 bytes -> mac_tx_data matches src0 bytewise, src0_ack pulses once, probe_frames=1, next grant no earlier than 12 idle cycles later.
- src0 and src1 request simultaneously and continuously -> grants alternate 0,1,0,1; both counters equal after 4 frames.
- Granted source never asserts dvld -> grant drops at cycle 64, counter unchanged, other requester granted after IFG.
- cfg_jumbo_en toggled mid-frame -> conf_tx_jumbo_en changes only in the IDLE cycle after the IFG.
- reset_n asserted during XFER -> mac_tx_dvld, gnt and counters 0 without a clock edge; the first grant after release goes to src0.

Source files
------------

// File: rtl/tx_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler_if
//
// Bundles the two frame-source handshakes and the MAC TX client handshake
// that the scheduler sits between (all in the tx_clk domain).
//
// Signals:
//   srcN_req   source -> scheduler   level request, held until the frame ends
//   srcN_gnt   scheduler -> source   registered grant, at most one high
//   srcN_data  source -> scheduler   source byte
//   srcN_dvld  source -> scheduler   source data valid
//   srcN_ack   scheduler -> source   mac_tx_ack gated by the source's grant
//   mac_tx_*   scheduler <-> MAC     muxed byte/valid out, first-byte ack in
//
// Modports:
//   master  the scheduler side
//   slave   the sources + MAC side
// ----------------------------------------------------------------------------
interface tx_frame_scheduler_if;

    logic       src0_req;
    logic       src0_gnt;
    logic [7:0] src0_data;
    logic       src0_dvld;
    logic       src0_ack;

    logic       src1_req;
    logic       src1_gnt;
    logic [7:0] src1_data;
    logic       src1_dvld;
    logic       src1_ack;

    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack;

    modport master (
        input  src0_req, src0_data, src0_dvld,
        input  src1_req, src1_data, src1_dvld,
        input  mac_tx_ack,
        output src0_gnt, src0_ack,
        output src1_gnt, src1_ack,
        output mac_tx_data, mac_tx_dvld
    );

    modport slave (
        output src0_req, src0_data, src0_dvld,
        output src1_req, src1_data, src1_dvld,
        output mac_tx_ack,
        input  src0_gnt, src0_ack,
        input  src1_gnt, src1_ack,
        input  mac_tx_data, mac_tx_dvld
    );

endinterface

// File: rtl/tx_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler
//
// Shares the single MAC TX client port between the probe-frame generator
// (src0) and a control-frame source (src1). Issues periodic probe triggers,
// arbitrates the MAC port round-robin, enforces an inter-frame gap, applies
// MAC TX configuration only between frames and counts completed frames.
//
// Ports:
//   tx_clk             TX clock, rising edge
//   reset_n            asynchronous active-low reset
//   sched_en           enables probe triggers and new grants
//   probe_period       trigger interval in cycles, 0 disables triggers
//   cfg_jumbo_en       requested jumbo setting
//   cfg_no_gen_crc     requested no-CRC-generation setting
//   probe_trig         one-cycle probe request pulse to src0
//   conf_tx_en         MAC TX enable
//   conf_tx_jumbo_en   MAC jumbo enable
//   conf_tx_no_gen_crc MAC CRC-generation disable
//   probe_frames       completed src0 frames (wrapping)
//   ctrl_frames        completed src1 frames (wrapping)
//   bus                source / MAC handshakes (master side)
//
// IFG_CYCLES and GRANT_TIMEOUT are expected to be at least 1.
// ----------------------------------------------------------------------------
module tx_frame_scheduler #(
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned GRANT_TIMEOUT = 64,
    parameter int unsigned PERIOD_W      = 24
) (
    input  logic                tx_clk,
    input  logic                reset_n,
    input  logic                sched_en,
    input  logic [PERIOD_W-1:0] probe_period,
    input  logic                cfg_jumbo_en,
    input  logic                cfg_no_gen_crc,
    output logic                probe_trig,
    output logic                conf_tx_en,
    output logic                conf_tx_jumbo_en,
    output logic                conf_tx_no_gen_crc,
    output logic [15:0]         probe_frames,
    output logic [15:0]         ctrl_frames,
    tx_frame_scheduler_if.master bus
);

    // One shared cycle counter serves both the grant timeout and the IFG.
    localparam int unsigned CycMax = (IFG_CYCLES > GRANT_TIMEOUT) ? IFG_CYCLES : GRANT_TIMEOUT;
    localparam int unsigned CycW   = $clog2(CycMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StWaitAck,
        StXfer,
        StIfg
    } state_e;

    state_e              state_q, state_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rr_q, rr_d;       // 1: src1 wins the next tie
    logic [CycW-1:0]     cyc_q, cyc_d;
    logic [15:0]         probe_frames_q, probe_frames_d;
    logic [15:0]         ctrl_frames_q, ctrl_frames_d;
    logic                conf_en_q, conf_en_d;
    logic                conf_jumbo_q, conf_jumbo_d;
    logic                conf_nocrc_q, conf_nocrc_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic                probe_trig_q, probe_trig_d;

    logic                sel_dvld;
    logic                pick1;

    // ------------------------------------------------------------------
    // Probe trigger
    // ------------------------------------------------------------------
    always_comb begin
        period_cnt_d = '0;
        probe_trig_d = 1'b0;
        if (sched_en && (probe_period != '0)) begin
            // >= rather than == so a lowered period fires on the next cycle
            if (period_cnt_q >= (probe_period - PERIOD_W'(1))) begin
                probe_trig_d = 1'b1;
            end else begin
                period_cnt_d = period_cnt_q + PERIOD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mux: zero latency from the registered grant
    // ------------------------------------------------------------------
    always_comb begin
        bus.mac_tx_data = 8'h00;
        sel_dvld        = 1'b0;
        if (gnt0_q) begin
            bus.mac_tx_data = bus.src0_data;
            sel_dvld        = bus.src0_dvld;
        end else if (gnt1_q) begin
            bus.mac_tx_data = bus.src1_data;
            sel_dvld        = bus.src1_dvld;
        end
    end

    assign bus.mac_tx_dvld = sel_dvld;
    assign bus.src0_gnt    = gnt0_q;
    assign bus.src1_gnt    = gnt1_q;
    assign bus.src0_ack    = bus.mac_tx_ack & gnt0_q;
    assign bus.src1_ack    = bus.mac_tx_ack & gnt1_q;

    // src1 wins if it is the only requester, or on a tie when it holds priority
    assign pick1 = bus.src1_req && (!bus.src0_req || rr_q);

    // ------------------------------------------------------------------
    // Arbitration / frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        gnt0_d         = gnt0_q;
        gnt1_d         = gnt1_q;
        rr_d           = rr_q;
        cyc_d          = cyc_q;
        probe_frames_d = probe_frames_q;
        ctrl_frames_d  = ctrl_frames_q;
        conf_en_d      = conf_en_q;
        conf_jumbo_d   = conf_jumbo_q;
        conf_nocrc_d   = conf_nocrc_q;

        case (state_q)
            StIdle: begin
                conf_en_d    = sched_en;
                conf_jumbo_d = cfg_jumbo_en;
                conf_nocrc_d = cfg_no_gen_crc;
                if (sched_en && (bus.src0_req || bus.src1_req)) begin
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    rr_d    = !pick1;
                    cyc_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (sel_dvld) begin
                    state_d = StWaitAck;
                end else if (cyc_q == CycW'(GRANT_TIMEOUT - 1)) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = StIfg;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StWaitAck: begin
                // valid dropping before the MAC took the first byte is an abort
                if (!sel_dvld) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = StIfg;
                end else if (bus.mac_tx_ack) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (!sel_dvld) begin
                    if (gnt0_q) begin
                        probe_frames_d = probe_frames_q + 16'd1;
                    end else begin
                        ctrl_frames_d = ctrl_frames_q + 16'd1;
                    end
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = StIfg;
                end
            end
            StIfg: begin
                if (cyc_q == CycW'(IFG_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                cyc_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            rr_q           <= 1'b0;
            cyc_q          <= '0;
            probe_frames_q <= '0;
            ctrl_frames_q  <= '0;
            conf_en_q      <= 1'b0;
            conf_jumbo_q   <= 1'b0;
            conf_nocrc_q   <= 1'b0;
            period_cnt_q   <= '0;
            probe_trig_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt0_q         <= gnt0_d;
            gnt1_q         <= gnt1_d;
            rr_q           <= rr_d;
            cyc_q          <= cyc_d;
            probe_frames_q <= probe_frames_d;
            ctrl_frames_q  <= ctrl_frames_d;
            conf_en_q      <= conf_en_d;
            conf_jumbo_q   <= conf_jumbo_d;
            conf_nocrc_q   <= conf_nocrc_d;
            period_cnt_q   <= period_cnt_d;
            probe_trig_q   <= probe_trig_d;
        end
    end

    assign probe_trig         = probe_trig_q;
    assign conf_tx_en         = conf_en_q;
    assign conf_tx_jumbo_en   = conf_jumbo_q;
    assign conf_tx_no_gen_crc = conf_nocrc_q;
    assign probe_frames       = probe_frames_q;
    assign ctrl_frames        = ctrl_frames_q;

endmodule
